tl_arbiter: RTL

Two-master, single-slave arbiter for the A/D request-response link. It shares one slave port (memory or peripheral) between two `master` instances, such as a core-side master and a DMA master. It grants one request at a time with round-robin priority and holds the slave until the matching D response returns. It then routes that response back to the granted master only.

---
 rtl/tl_pkg.sv | 41 ++++
 rtl/rr_pick2.sv | 20 ++
 rtl/tl_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared field layout, opcodes and FSM state type for the tl_arbiter A/D link.
package tl_pkg;

    localparam int OPC_W  = 3;
    localparam int SRC_W  = 2;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam int A_OPC_LSB   = 52;
    localparam int A_PARAM_LSB = 49;
    localparam int A_SIZE_LSB  = 46;
    localparam int A_SRC_LSB   = 44;
    localparam int A_ADDR_LSB  = 34;
    localparam int A_DATA_LSB  = 2;
    localparam int A_VALID_BIT = 1;
    localparam int A_READY_BIT = 0;

    localparam int D_OPC_LSB   = 37;
    localparam int D_SRC_LSB   = 35;
    localparam int D_ERR_BIT   = 34;
    localparam int D_DATA_LSB  = 2;
    localparam int D_VALID_BIT = 1;
    localparam int D_READY_BIT = 0;

    localparam logic [OPC_W-1:0] GET      = 3'd4;
    localparam logic [OPC_W-1:0] PUT_FULL = 3'd0;
    localparam logic [OPC_W-1:0] ACK      = 3'd0;
    localparam logic [OPC_W-1:0] ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_D = 2'd2
    } state_e;

    // Response opcode a slave would return for a given request opcode.
    function automatic logic [OPC_W-1:0] resp_opcode(input logic [OPC_W-1:0] a_opc);
        return (a_opc == GET) ? ACK_DATA : ACK;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot grant from two valids and the last winner.
module rr_pick2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        case ({valid1_i, valid0_i})
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/tl_arbiter.sv
// Round-robin two-master / one-slave A/D arbiter, one transaction outstanding.
// Optional WAIT_D timeout with synthetic error response: define TL_ARB_TIMEOUT_EN.
module tl_arbiter
    import tl_pkg::*;
#(
    parameter int A_W            = 55,
    parameter int D_W            = 40,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [A_W-1:0] a_channel_m0,
    input  logic [A_W-1:0] a_channel_m1,
    output logic           a_ready_m0,
    output logic           a_ready_m1,
    output logic [D_W-1:0] d_channel_m0,
    output logic [D_W-1:0] d_channel_m1,
    output logic [A_W-1:0] a_channel_s,
    input  logic           a_ready_s,
    input  logic [D_W-1:0] d_channel_s,
    output logic [1:0]     grant,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic           last_grant_q, last_grant_d;
    logic [A_W-1:0] req_q, req_d;
    logic           a_valid_q, a_valid_d;
    logic           rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [D_W-1:0] dm0_q, dm0_d, dm1_q, dm1_d;
    logic           busy_q;
    logic [1:0]     pick;
    logic           timeout_hit;
    logic [D_W-1:0] synth_d;
    logic [D_W-1:0] resp;
    logic           done;

    rr_pick2 u_pick (
        .valid0_i     (a_channel_m0[A_VALID_BIT]),
        .valid1_i     (a_channel_m1[A_VALID_BIT]),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );

`ifdef TL_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counter is zeroed while issuing, so it starts at 0 on the first WAIT_D cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE)       cnt_d = 8'd0;
        else if (state_q == WAIT_D) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign synth_d     = D_W'({resp_opcode(req_q[A_OPC_LSB +: OPC_W]),
                               req_q[A_SRC_LSB +: SRC_W], 1'b1,
                               {DATA_W{1'b0}}, 1'b1, 1'b0});
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign synth_d        = '0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        a_valid_d    = a_valid_q;
        rdy0_d       = 1'b0;
        rdy1_d       = 1'b0;
        dm0_d        = '0;
        dm1_d        = '0;
        resp         = '0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    grant_d   = pick;
                    req_d     = pick[0] ? a_channel_m0 : a_channel_m1;
                    a_valid_d = 1'b1;
                    rdy0_d    = pick[0];
                    rdy1_d    = pick[1];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (a_ready_s) begin
                    a_valid_d = 1'b0;
                    state_d   = WAIT_D;
                end
            end
            WAIT_D: begin
                // A real response on the timeout edge takes precedence.
                if (d_channel_s[D_VALID_BIT]) begin
                    resp = {d_channel_s[D_W-1:1], 1'b0};
                    done = 1'b1;
                end else if (timeout_hit) begin
                    resp = synth_d;
                    done = 1'b1;
                end
                if (done) begin
                    dm0_d        = grant_q[0] ? resp : '0;
                    dm1_d        = grant_q[1] ? resp : '0;
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            // NOTE: the request holding register is reset too, since it drives a_channel_s directly.
            req_q        <= '0;
            a_valid_q    <= 1'b0;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            dm0_q        <= '0;
            dm1_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            a_valid_q    <= a_valid_d;
            rdy0_q       <= rdy0_d;
            rdy1_q       <= rdy1_d;
            dm0_q        <= dm0_d;
            dm1_q        <= dm1_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign a_channel_s  = {req_q[A_W-1:2], a_valid_q, 1'b0};
    assign a_ready_m0   = rdy0_q;
    assign a_ready_m1   = rdy1_q;
    assign d_channel_m0 = dm0_q;
    assign d_channel_m1 = dm1_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

    logic unused_bits;
    assign unused_bits = ^{a_channel_m0[A_READY_BIT], a_channel_m1[A_READY_BIT],
                           d_channel_s[D_READY_BIT], req_q[1:0]};

endmodule
